// File: rtl/chess_countdown_timer.sv
// Per-player BCD mm:ss countdown driven by the chess-clock FSM enables.
// Optional Fischer increment on count release: define CHESS_INCREMENT_EN.
module chess_countdown_timer #(
  parameter int CLK_HZ    = 50000000,
  parameter int START_MIN = 5,
  parameter int START_SEC = 0,
  parameter int INC_SEC   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        count1,
  input  logic        count2,
  output logic [15:0] p1_time,
  output logic [15:0] p2_time,
  output logic        flag1,
  output logic        flag2,
  output logic        tick
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PMAX = PW'(CLK_HZ - 1);
  localparam logic [15:0] START_BCD = {
    4'(START_MIN / 10), 4'(START_MIN % 10),
    4'(START_SEC / 10), 4'(START_SEC % 10)
  };

  if (CLK_HZ < 1 || START_MIN > 99 || START_SEC > 59 ||
      INC_SEC < 0 || INC_SEC > 59) begin : g_bad_param
    $error("chess_countdown_timer: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, RUN, TIMEOUT} state_t;

  state_t        state;
  state_t        state_nx;
  logic [PW-1:0] presc;
  logic          en1;
  logic          en2;
  logic          run;
  logic          wrap;
  logic          dec1;
  logic          dec2;
  logic          expire;
  logic [15:0]   nx1;
  logic [15:0]   nx2;

  // Borrowing BCD decrement that stops at 00:00.
  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [3:0] d3, d2, d1, d0;
    {d3, d2, d1, d0} = t;
    if (t != 16'h0000) begin
      if (d0 != 4'd0) d0 = d0 - 4'd1;
      else begin
        d0 = 4'd9;
        if (d1 != 4'd0) d1 = d1 - 4'd1;
        else begin
          d1 = 4'd5;
          if (d2 != 4'd0) d2 = d2 - 4'd1;
          else begin
            d2 = 4'd9;
            d3 = d3 - 4'd1;
          end
        end
      end
    end
    return {d3, d2, d1, d0};
  endfunction

  assign en1 = count1 & ~count2;
  assign en2 = count2 & ~count1;

`ifdef CHESS_INCREMENT_EN
  logic c1_q;
  logic c2_q;
  logic fall1;
  logic fall2;

  // Adds INC_SEC with carry, saturating at 99:59.
  function automatic logic [15:0] bcd_inc(input logic [15:0] t);
    int m, s, tot;
    m   = int'(t[15:12]) * 10 + int'(t[11:8]);
    s   = int'(t[7:4]) * 10 + int'(t[3:0]);
    tot = m * 60 + s + INC_SEC;
    if (tot > 5999) tot = 5999;
    m = tot / 60;
    s = tot % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  // Previous count levels for release detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c1_q <= 1'b0;
      c2_q <= 1'b0;
    end else begin
      c1_q <= count1;
      c2_q <= count2;
    end
  end

  assign fall1 = c1_q & ~count1 & (state != TIMEOUT);
  assign fall2 = c2_q & ~count2 & (state != TIMEOUT);
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; load and expiry override the normal flow.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (en1 | en2) state_nx = RUN;
      RUN:     if (!(en1 | en2)) state_nx = IDLE;
      TIMEOUT: state_nx = TIMEOUT;
      default: state_nx = IDLE;
    endcase
    if (expire) state_nx = TIMEOUT;
    if (load)   state_nx = IDLE;
  end

  // Control decode: counting, second wrap and expiry.
  always_comb begin
    run    = (state != TIMEOUT) & (en1 | en2);
    wrap   = run & (presc == PMAX);
    dec1   = wrap & en1;
    dec2   = wrap & en2;
    expire = (dec1 & (p1_time <= 16'h0001)) |
             (dec2 & (p2_time <= 16'h0001));
  end

  // Next player times: decrement, then optional increment.
  always_comb begin
    nx1 = dec1 ? bcd_dec(p1_time) : p1_time;
    nx2 = dec2 ? bcd_dec(p2_time) : p2_time;
`ifdef CHESS_INCREMENT_EN
    if (fall1) nx1 = bcd_inc(nx1);
    if (fall2) nx2 = bcd_inc(nx2);
`endif
  end

  // Prescaler, times, sticky flags and registered tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc   <= '0;
      p1_time <= START_BCD;
      p2_time <= START_BCD;
      flag1   <= 1'b0;
      flag2   <= 1'b0;
      tick    <= 1'b0;
    end else if (load) begin
      presc   <= '0;
      p1_time <= START_BCD;
      p2_time <= START_BCD;
      flag1   <= 1'b0;
      flag2   <= 1'b0;
      tick    <= 1'b0;
    end else begin
      tick    <= wrap;
      p1_time <= nx1;
      p2_time <= nx2;
      if (run) presc <= wrap ? '0 : presc + 1'b1;
      if (dec1 && p1_time <= 16'h0001) flag1 <= 1'b1;
      if (dec2 && p2_time <= 16'h0001) flag2 <= 1'b1;
    end
  end

endmodule

// File: tb/tb_chess_countdown_timer.sv
// Bench for chess_countdown_timer: vector table, corner sequences,
// and random stimulus against a seconds-based reference model.
module tb_chess_countdown_timer;

  localparam int HZ    = 4;
  localparam int START = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic        c1 = 1'b0;
  logic        c2 = 1'b0;
  logic        bc2 = 1'b0;
  logic [15:0] p1, p2, bp1, bp2;
  logic        f1, f2, tk, bf1, bf2, btk;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  chess_countdown_timer #(
    .CLK_HZ(HZ), .START_MIN(0), .START_SEC(3), .INC_SEC(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load(load),
    .count1(c1), .count2(c2),
    .p1_time(p1), .p2_time(p2),
    .flag1(f1), .flag2(f2), .tick(tk)
  );

  chess_countdown_timer #(
    .CLK_HZ(HZ), .START_MIN(1), .START_SEC(0), .INC_SEC(2)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .load(1'b0),
    .count1(1'b0), .count2(bc2),
    .p1_time(bp1), .p2_time(bp2),
    .flag1(bf1), .flag2(bf2), .tick(btk)
  );

  typedef struct {
    logic        ld;
    logic        a;
    logic        b;
    int          n;
    logic [15:0] e1;
    logic [15:0] e2;
    logic        ef1;
    logic        ef2;
    logic        etk;
  } vec_t;

  vec_t tbl[11];

  int m_s1, m_s2, m_pre;
  bit m_to, m_f1, m_f2, m_tk;

  function automatic logic [15:0] to_bcd(input int s);
    int m, q;
    m = s / 60;
    q = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(q / 10), 4'(q % 10)};
  endfunction

  task automatic model_load();
    m_s1 = START; m_s2 = START; m_pre = 0;
    m_to = 0; m_f1 = 0; m_f2 = 0; m_tk = 0;
  endtask

  task automatic model_step();
    bit e1, e2;
    e1 = c1 && !c2;
    e2 = c2 && !c1;
    if (load) begin
      model_load();
      return;
    end
    m_tk = 0;
    if (!m_to && (e1 || e2)) begin
      if (m_pre == HZ - 1) begin
        m_pre = 0;
        m_tk = 1;
        if (e1) begin
          if (m_s1 > 0) m_s1 = m_s1 - 1;
          if (m_s1 == 0) begin m_f1 = 1; m_to = 1; end
        end else begin
          if (m_s2 > 0) m_s2 = m_s2 - 1;
          if (m_s2 == 0) begin m_f2 = 1; m_to = 1; end
        end
      end else begin
        m_pre = m_pre + 1;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [15:0] x1, input logic [15:0] x2,
                     input logic xf1, input logic xf2, input logic xt);
    checks++;
    if (p1 !== x1 || p2 !== x2 || f1 !== xf1 || f2 !== xf2 || tk !== xt) begin
      errors++;
      $display("FAIL %s: got p1=%h p2=%h f1=%b f2=%b tick=%b, want p1=%h p2=%h f1=%b f2=%b tick=%b",
               nm, p1, p2, f1, f2, tk, x1, x2, xf1, xf2, xt);
    end
  endtask

  task automatic chk_bcd(input string nm, input logic [15:0] t);
    checks++;
    if (t[3:0] > 4'd9 || t[7:4] > 4'd5 || t[11:8] > 4'd9 || t[15:12] > 4'd9) begin
      errors++;
      $display("FAIL %s: got %h, want valid mm:ss BCD", nm, t);
    end
  endtask

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 4,  16'h0002, 16'h0003, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 4,  16'h0001, 16'h0003, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 4,  16'h0000, 16'h0003, 1'b1, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 8,  16'h0000, 16'h0003, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 4,  16'h0000, 16'h0003, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1,  16'h0003, 16'h0003, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 20, 16'h0003, 16'h0003, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 2,  16'h0003, 16'h0003, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 2,  16'h0003, 16'h0002, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 3,  16'h0003, 16'h0002, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 4,  16'h0003, 16'h0001, 1'b0, 1'b0, 1'b1};

    #12 rst_n = 1'b1;
    chk("reset", 16'h0003, 16'h0003, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 11; i++) begin
      load = tbl[i].ld;
      c1   = tbl[i].a;
      c2   = tbl[i].b;
      repeat (tbl[i].n) cycle();
      chk($sformatf("vec%0d", i), tbl[i].e1, tbl[i].e2,
          tbl[i].ef1, tbl[i].ef2, tbl[i].etk);
    end
    load = 1'b0; c1 = 1'b0; c2 = 1'b1;

    repeat (4) cycle();
    chk("p2_expire", 16'h0003, 16'h0000, 1'b0, 1'b1, 1'b1);
    c2 = 1'b0;
    cycle();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_rst", 16'h0003, 16'h0003, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b1;

    @(posedge clk);
    #1;
    bc2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk_bcd("b_bcd", bp2);
    end
    bc2 = 1'b0;
    checks++;
    if (bp2 !== 16'h0059 || bp1 !== 16'h0100 || bf2 !== 1'b0) begin
      errors++;
      $display("FAIL borrow: got p1=%h p2=%h f2=%b, want p1=0100 p2=0059 f2=0",
               bp1, bp2, bf2);
    end

    load = 1'b1;
    cycle();
    model_load();
    load = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      load = ($urandom_range(0, 99) < 2);
      c1   = 1'($urandom_range(0, 1));
      c2   = 1'($urandom_range(0, 1));
      cycle();
      model_step();
      chk("rand", to_bcd(m_s1), to_bcd(m_s2), m_f1, m_f2, m_tk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
